uart_tx: RTL and testbench

AXI-stream to serial UART transmitter, the transmit-side companion of the existing uart_rx. Accepts one DATA_WIDTH word per handshake and shifts it out on txd as start bit, data bits LSB first, optional parity bit and 1 or 2 stop bits. Bit timing uses the same prescale convention as uart_rx, so one prescale value drives both directions of a UART link: bit period = prescale*8 clk cycles.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_if.sv | 8 +
 rtl/uart_baud_timer.sv | 18 +
 rtl/uart_tx.sv | 114 +++++++++++
 tb/tb_uart_tx.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants, state type and bit-timing helper shared by the UART transmitter and receiver
package uart_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;
    localparam int OVERSAMPLE  = 8;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    function automatic logic [18:0] bit_cycles_m1(input logic [15:0] prescale);
        logic [15:0] p;
        p = (prescale == 16'd0) ? 16'd1 : prescale;
        return 19'(p) * 19'(OVERSAMPLE) - 19'd1;
    endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: AXI-stream word handshake feeding the UART transmitter
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_baud_timer.sv
// uart_baud_timer: loadable bit-period down-counter, flags the last cycle of a bit
module uart_baud_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [18:0] load_val,
    output logic        bit_end
);
    logic [18:0] count;

    // a load restarts the bit; otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (load) count <= load_val;
        else if (count != '0) count <= count - 19'd1;

    assign bit_end = count == '0;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: AXI-stream to serial UART transmitter (start, data LSB first, optional parity, stop bits)
module uart_tx import uart_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = PARITY_NONE,
    parameter int STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_if.slave        s_axis,
    input  logic [15:0]     prescale,
    output logic            txd,
    output logic            busy
);
    tx_state_t             state, state_d;
    logic [DATA_WIDTH-1:0] shift, shift_d;
    logic [3:0]            bit_cnt, bit_cnt_d;
    logic                  stop_cnt, stop_cnt_d;
    logic                  par, par_d;
    logic [15:0]           presc, presc_d;
    logic                  tready, txd_d, busy_d, tready_d;
    logic                  load, bit_end;
    logic [18:0]           load_val;

    assign s_axis.tready = tready;
    assign load_val = bit_cycles_m1(state == TX_IDLE ? prescale : presc);

    uart_baud_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .bit_end  (bit_end)
    );

    // frame state and registered outputs; reset parks the line idle high
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= TX_IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            presc    <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            tready   <= 1'b0;
        end else begin
            state    <= state_d;
            shift    <= shift_d;
            bit_cnt  <= bit_cnt_d;
            stop_cnt <= stop_cnt_d;
            par      <= par_d;
            presc    <= presc_d;
            txd      <= txd_d;
            busy     <= busy_d;
            tready   <= tready_d;
        end

    // next-state: advance one frame bit per timer expiry; outputs follow the next state
    always_comb begin
        state_d    = state;
        shift_d    = shift;
        bit_cnt_d  = bit_cnt;
        stop_cnt_d = stop_cnt;
        par_d      = par;
        presc_d    = presc;
        load       = 1'b0;
        case (state)
            TX_IDLE:
                if (s_axis.tvalid && tready) begin
                    shift_d = s_axis.tdata;
                    presc_d = prescale;
                    par_d   = (PARITY == PARITY_ODD) ? ~^s_axis.tdata : ^s_axis.tdata;
                    load    = 1'b1;
                    state_d = TX_START;
                end
            TX_START:
                if (bit_end) begin
                    load      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = TX_DATA;
                end
            TX_DATA:
                if (bit_end) begin
                    load       = 1'b1;
                    shift_d    = shift >> 1;
                    bit_cnt_d  = bit_cnt + 4'd1;
                    stop_cnt_d = 1'b0;
                    if (bit_cnt == 4'(DATA_WIDTH - 1))
                        state_d = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
                end
            TX_PARITY:
                if (bit_end) begin
                    load       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = TX_STOP;
                end
            TX_STOP:
                if (bit_end) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) state_d = TX_IDLE;
                    else begin
                        load       = 1'b1;
                        stop_cnt_d = 1'b1;
                    end
                end
            default: state_d = TX_IDLE;
        endcase
        txd_d    = (state_d == TX_START)  ? 1'b0 :
                   (state_d == TX_DATA)   ? shift_d[0] :
                   (state_d == TX_PARITY) ? par_d : 1'b1;
        busy_d   = state_d != TX_IDLE;
        tready_d = state_d == TX_IDLE;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx across none/even/odd parity and 1/2 stop bit builds
module tb_uart_tx;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  tvalid = '0;
    logic [7:0]  tdata = '0;
    logic [15:0] prescale = 16'd1;
    logic        txd_a, txd_b, txd_c, busy_a, busy_b, busy_c;
    logic [2:0]  txd, busy, tready;
    int          checks = 0;
    int          errors = 0;
    time         t0, t1;

    uart_tx_if #(.DATA_WIDTH(8)) if_a ();
    uart_tx_if #(.DATA_WIDTH(8)) if_b ();
    uart_tx_if #(.DATA_WIDTH(8)) if_c ();

    assign if_a.tdata  = tdata;
    assign if_b.tdata  = tdata;
    assign if_c.tdata  = tdata;
    assign if_a.tvalid = tvalid[0];
    assign if_b.tvalid = tvalid[1];
    assign if_c.tvalid = tvalid[2];
    assign txd    = {txd_c, txd_b, txd_a};
    assign busy   = {busy_c, busy_b, busy_a};
    assign tready = {if_c.tready, if_b.tready, if_a.tready};

    uart_tx #(.DATA_WIDTH(8), .PARITY(PARITY_NONE), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_axis(if_a.slave), .prescale(prescale), .txd(txd_a), .busy(busy_a));
    uart_tx #(.DATA_WIDTH(8), .PARITY(PARITY_EVEN), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_axis(if_b.slave), .prescale(prescale), .txd(txd_b), .busy(busy_b));
    uart_tx #(.DATA_WIDTH(8), .PARITY(PARITY_ODD), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .s_axis(if_c.slave), .prescale(prescale), .txd(txd_c), .busy(busy_c));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // wait until the negedge that lies in cycle m after the handshake edge at t
    task automatic at_cycle(input time t, input int m);
        time tgt;
        tgt = t + time'(m * 10 + 5);
        if (tgt > $time) #(tgt - $time);
    endtask

    task automatic send(input int i, input logic [7:0] d, input bit hold, output time ths);
        int n;
        n = 0;
        tdata = d;
        tvalid[i] = 1'b1;
        while (!tready[i] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("handshake_ready%0d", i), tready[i], 1'b1);
        @(posedge clk);
        ths = $time;
        @(negedge clk);
        if (!hold) begin
            tvalid[i] = 1'b0;
            tdata = ~d;
        end
    endtask

    // bits is LSB = start bit; checks first and last cycle of every bit, then the return to idle
    task automatic check_frame(input int i, input logic [11:0] bits, input int n, input int p,
                               input time ths, input int k0, input string tag);
        for (int k = k0; k < n; k++) begin
            at_cycle(ths, k * p);
            chk($sformatf("%s_bit%0d_first", tag, k), txd[i], bits[k]);
            chk($sformatf("%s_busy%0d", tag, k), busy[i], 1'b1);
            at_cycle(ths, k * p + p - 1);
            chk($sformatf("%s_bit%0d_last", tag, k), txd[i], bits[k]);
        end
        chk($sformatf("%s_tready_low_at_end", tag), tready[i], 1'b0);
        at_cycle(ths, n * p);
        chk($sformatf("%s_tready_back", tag), tready[i], 1'b1);
        chk($sformatf("%s_busy_clear", tag), busy[i], 1'b0);
        chk($sformatf("%s_txd_idle", tag), txd[i], 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_txd%0d", i), txd[i], 1'b1);
            chk($sformatf("reset_tready%0d", i), tready[i], 1'b0);
            chk($sformatf("reset_busy%0d", i), busy[i], 1'b0);
        end
        rst_n = 1'b1;
        chk("release_tready_still_low", tready[0], 1'b0);
        @(negedge clk);
        chk("release_tready_high", tready[0], 1'b1);

        prescale = 16'd1;
        send(0, 8'h55, 1'b0, t0);
        check_frame(0, 12'({1'b1, 8'h55, 1'b0}), 10, 8, t0, 0, "basic55");

        prescale = 16'd2;
        send(1, 8'h07, 1'b0, t0);
        check_frame(1, {2'b11, 1'b1, 8'h07, 1'b0}, 12, 16, t0, 0, "even07");
        send(2, 8'h07, 1'b0, t0);
        check_frame(2, 12'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 16, t0, 0, "odd07");

        prescale = 16'd1;
        send(1, 8'hA5, 1'b1, t0);
        tdata = 8'h3C;
        check_frame(1, {2'b11, 1'b0, 8'hA5, 1'b0}, 12, 8, t0, 0, "b2b_first");
        t1 = t0 + 970;
        at_cycle(t1, 0);
        tvalid[1] = 1'b0;
        tdata = 8'hFF;
        check_frame(1, {2'b11, 1'b0, 8'h3C, 1'b0}, 12, 8, t1, 0, "b2b_second");

        prescale = 16'd4;
        send(0, 8'h3C, 1'b0, t0);
        chk("latch_start_bit", txd[0], 1'b0);
        at_cycle(t0, 20);
        prescale = 16'd1;
        check_frame(0, 12'({1'b1, 8'h3C, 1'b0}), 10, 32, t0, 1, "latch_p4");
        send(0, 8'h81, 1'b0, t0);
        check_frame(0, 12'({1'b1, 8'h81, 1'b0}), 10, 8, t0, 0, "latch_p1");
        prescale = 16'd0;
        send(0, 8'hC3, 1'b0, t0);
        check_frame(0, 12'({1'b1, 8'hC3, 1'b0}), 10, 8, t0, 0, "prescale0");

        prescale = 16'd1;
        send(0, 8'h00, 1'b0, t0);
        at_cycle(t0, 35);
        chk("midreset_data_bit3_low", txd[0], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_txd", txd[0], 1'b1);
        chk("midreset_tready", tready[0], 1'b0);
        chk("midreset_busy", busy[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_release_tready_low", tready[0], 1'b0);
        chk("midreset_release_txd", txd[0], 1'b1);
        @(negedge clk);
        chk("midreset_release_tready_high", tready[0], 1'b1);
        send(0, 8'hFF, 1'b0, t0);
        check_frame(0, 12'({1'b1, 8'hFF, 1'b0}), 10, 8, t0, 0, "after_reset_ff");

        send(2, 8'h96, 1'b0, t0);
        chk("nohs_start_bit", txd[2], 1'b0);
        at_cycle(t0, 2);
        tvalid[2] = 1'b1;
        at_cycle(t0, 4);
        tvalid[2] = 1'b0;
        tdata = 8'h00;
        at_cycle(t0, 6);
        tvalid[2] = 1'b1;
        at_cycle(t0, 9);
        tvalid[2] = 1'b0;
        check_frame(2, 12'({1'b1, 1'b1, 8'h96, 1'b0}), 11, 8, t0, 2, "nohs96");
        at_cycle(t0, 92);
        chk("nohs_no_extra_busy", busy[2], 1'b0);
        chk("nohs_no_extra_txd", txd[2], 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
